// File: rtl/orb_pkg.sv
// Shared definitions for the orbital-stream reader: word layout, FSM encoding and word formatting.
package orb_pkg;

  localparam int WORD_W     = 12;
  localparam int MARKER_BIT = 0;
  localparam int PARITY_BIT = 11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_SHIFT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_LOAD  = ST_LOAD,
    S_SHIFT = ST_SHIFT
  } orb_state_e;

  // Parity covers the data field plus the parity bit itself; the frame marker is left out
  // so that marking word 0 never changes the parity of the payload.
  function automatic logic [WORD_W-1:0] orb_fmt(input logic [WORD_W-1:0] data,
                                                input logic              first);
    logic [WORD_W-1:0] r;
    r             = data;
    r[MARKER_BIT] = first;
    r[PARITY_BIT] = ~(^r[PARITY_BIT-1:MARKER_BIT+1]);
    return r;
  endfunction

endpackage

// File: rtl/orb_bit_timer.sv
// Serial bit timer: divides clk by BIT_DIV, flags the first and last clk of every bit.
module orb_bit_timer #(
  parameter int BIT_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic stb_o,
  output logic wrap_o
);

  localparam int               CNT_W = $clog2(BIT_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIT_DIV - 1);

  logic [CNT_W-1:0] divCnt_q, divCnt_d;

  always_comb begin
    divCnt_d = divCnt_q + 1'b1;
    if (clr_i || divCnt_q == LAST) divCnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) divCnt_q <= '0;
    else      divCnt_q <= divCnt_d;
  end

  assign stb_o  = ~clr_i & (divCnt_q == '0);
  assign wrap_o = ~clr_i & (divCnt_q == LAST);

endmodule

// File: rtl/orb_frame_reader.sv
// Orbital-stream reader: drains one ping-pong bank as MSB-first serial words while the packer
// fills the other bank, selected through sw_out.
module orb_frame_reader #(
  parameter int ADDR_W      = 11,
  parameter int WORD_W      = 12,
  parameter int FRAME_WORDS = 1024,
  parameter int BIT_DIV     = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] rdData,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              rdEn,
  output logic              sw_out,
  output logic              serOut,
  output logic              bitStb,
  output logic              frameStart,
  output logic              busy
);
  import orb_pkg::*;

  localparam int               IDX_W    = ADDR_W - 1;
  localparam int               BC_W     = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
  localparam logic [BC_W-1:0]  TOP_BIT  = BC_W'(WORD_W - 1);

  orb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              bank_q, bank_d;
  logic              rdBank_q, rdBank_d;
  logic              first_q, first_d;
  logic [BC_W-1:0]   bitCnt_q, bitCnt_d;
  logic              pend_q, pend_d;
  logic              cap_q, cap_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] nextWord_q, nextWord_d;
  logic              fetch;
  logic              stb, wrap;

  orb_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != S_SHIFT),
    .stb_o  (stb),
    .wrap_o (wrap)
  );

  // idx_q/bank_q always point at the next word to fetch; rdBank_q is the bank last fetched.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bank_d     = bank_q;
    rdBank_d   = rdBank_q;
    first_d    = first_q;
    bitCnt_d   = bitCnt_q;
    pend_d     = pend_q;
    cap_d      = 1'b0;
    shreg_d    = shreg_q;
    nextWord_d = nextWord_q;
    fetch      = 1'b0;

    if (cap_q) nextWord_d = orb_fmt(rdData, first_q);

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_FETCH;
      end
      S_FETCH: begin
        fetch   = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shreg_d  = orb_fmt(rdData, first_q);
        bitCnt_d = TOP_BIT;
        pend_d   = 1'b0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        // en only matters at the start of the last bit, where the prefetch decision is made
        if (stb && bitCnt_q == '0 && en) begin
          fetch  = 1'b1;
          pend_d = 1'b1;
          cap_d  = 1'b1;
        end
        if (wrap) begin
          if (bitCnt_q != '0) begin
            shreg_d  = {shreg_q[WORD_W-2:0], 1'b0};
            bitCnt_d = bitCnt_q - 1'b1;
          end else if (pend_q) begin
            shreg_d  = nextWord_q;
            bitCnt_d = TOP_BIT;
            pend_d   = 1'b0;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fetch) begin
      first_d  = (idx_q == '0);
      rdBank_d = bank_q;
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        bank_d = ~bank_q;
      end else begin
        idx_d  = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      bank_q   <= 1'b0;
      rdBank_q <= 1'b0;
      first_q  <= 1'b0;
      bitCnt_q <= '0;
      pend_q   <= 1'b0;
      cap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bank_q   <= bank_d;
      rdBank_q <= rdBank_d;
      first_q  <= first_d;
      bitCnt_q <= bitCnt_d;
      pend_q   <= pend_d;
      cap_q    <= cap_d;
    end
  end

  // Word registers carry no reset: every output that reads them is qualified by state.
  always_ff @(posedge clk) begin
    shreg_q    <= shreg_d;
    nextWord_q <= nextWord_d;
  end

  // sw_out flips in the same clk as the rdEn that first reads the other bank.
  assign rdEn       = fetch;
  assign rdAddr     = {bank_q, idx_q};
  assign sw_out     = ~rdBank_d;
  assign serOut     = (state_q == S_SHIFT) & shreg_q[WORD_W-1];
  assign bitStb     = stb;
  assign frameStart = stb & (bitCnt_q == TOP_BIT) & shreg_q[MARKER_BIT];
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_orb_frame_reader.sv
// Directed bench for orb_frame_reader with a RAM model, fetch/word scoreboard and serial monitor.
module tb_orb_frame_reader;

  localparam int ADDR_W      = 11;
  localparam int WORD_W      = 12;
  localparam int FRAME_WORDS = 4;
  localparam int BIT_DIV     = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [WORD_W-1:0] rdData = '0;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdEn, sw_out, serOut, bitStb, frameStart, busy;

  logic [WORD_W-1:0] ram [0:2047];
  logic [ADDR_W-1:0] addr_q [$];
  logic [WORD_W-1:0] word_q [$];
  logic [WORD_W-1:0] rx_words [$];

  int n_vec = 0;
  int n_err = 0;
  int words_done = 0;
  int fs_cnt = 0;
  int base;

  int                bitpos = 0;
  int                since = 0;
  logic              have_prev = 1'b0;
  logic              held_ok = 1'b1;
  logic              cur_bit = 1'b0;
  logic [WORD_W-1:0] rx = '0;
  logic [WORD_W-1:0] exp_w = '0;
  logic [ADDR_W-1:0] ea;

  orb_frame_reader #(
    .ADDR_W      (ADDR_W),
    .WORD_W      (WORD_W),
    .FRAME_WORDS (FRAME_WORDS),
    .BIT_DIV     (BIT_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rdData     (rdData),
    .rdAddr     (rdAddr),
    .rdEn       (rdEn),
    .sw_out     (sw_out),
    .serOut     (serOut),
    .bitStb     (bitStb),
    .frameStart (frameStart),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rdEn) rdData <= ram[rdAddr];
  end

  function automatic logic [WORD_W-1:0] exp_fmt(input logic [WORD_W-1:0] d, input logic first);
    logic p;
    p = (($countones(d[10:1]) % 2) == 0);
    return {p, d[10:1], first};
  endfunction

  task automatic exp_fetch(input int a);
    logic [ADDR_W-1:0] aa;
    aa = ADDR_W'(a);
    addr_q.push_back(aa);
    word_q.push_back(exp_fmt(ram[a], aa[ADDR_W-2:0] == '0));
  endtask

  task automatic check_quiet(input string tag, input logic exp_sw);
    logic [16:0] got, want;
    got  = {rdEn, serOut, bitStb, frameStart, busy, sw_out, rdAddr};
    want = {5'b00000, exp_sw, 11'd0};
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: outputs %05h, required %05h", tag, got, want);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h, required %0h", tag, got, want);
    end
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (words_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    assert (words_done >= n) else begin
      n_err++;
      $error("FAIL %s: words received %0d, required %0d within %0d clk", tag, words_done, n, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    assert (busy === 1'b0) else begin
      n_err++;
      $error("FAIL %s: busy %b, required 0 within %0d clk", tag, busy, budget);
    end
  endtask

  // Monitor: fetch scoreboard, serial deserializer, bit timing and frame marker checks.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      bitpos    = 0;
      have_prev = 1'b0;
      since     = 0;
    end else begin
      since++;
      if (frameStart) fs_cnt++;
      if (rdEn) begin
        if (addr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL fetch_unexpected: rdEn at addr %0h, required no fetch", rdAddr);
        end else begin
          ea = addr_q.pop_front();
          n_vec++;
          assert (rdAddr === ea) else begin
            n_err++;
            $error("FAIL fetch_addr: got %0h, required %0h", rdAddr, ea);
          end
          n_vec++;
          assert (sw_out === ~ea[ADDR_W-1]) else begin
            n_err++;
            $error("FAIL sw_out_at_fetch: got %b, required %b (addr %0h)", sw_out, ~ea[ADDR_W-1], ea);
          end
        end
      end
      if (busy && !bitStb && have_prev && serOut !== cur_bit) held_ok = 1'b0;
      if (bitStb) begin
        if (have_prev && since <= 60) begin
          n_vec++;
          assert (since == BIT_DIV) else begin
            n_err++;
            $error("FAIL bit_spacing: got %0d clk, required %0d", since, BIT_DIV);
          end
          n_vec++;
          assert (held_ok) else begin
            n_err++;
            $error("FAIL bit_held: serOut changed inside a bit, required constant");
          end
        end
        since     = 0;
        have_prev = 1'b1;
        held_ok   = 1'b1;
        cur_bit   = serOut;
        if (bitpos == 0) begin
          rx = '0;
          if (word_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL word_unexpected: serial word started, required none");
            exp_w = '0;
          end else begin
            exp_w = word_q.pop_front();
          end
          n_vec++;
          assert (frameStart === exp_w[0]) else begin
            n_err++;
            $error("FAIL frameStart_first_bit: got %b, required %b", frameStart, exp_w[0]);
          end
        end else begin
          n_vec++;
          assert (frameStart === 1'b0) else begin
            n_err++;
            $error("FAIL frameStart_mid_word: got %b, required 0", frameStart);
          end
        end
        rx = {rx[WORD_W-2:0], serOut};
        bitpos++;
        if (bitpos == WORD_W) begin
          bitpos = 0;
          n_vec++;
          assert (rx === exp_w) else begin
            n_err++;
            $error("FAIL serial_word: got %03h, required %03h", rx, exp_w);
          end
          rx_words.push_back(rx);
          words_done++;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = WORD_W'((i * 37 + 5) & 12'hFFF);
    ram[0] = 12'h000;
    ram[1] = 12'h7FE;

    // Reset and idle with en low
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset_state", 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (100) @(negedge clk);
      check_quiet("idle_en_low", 1'b1);
    end

    // Continuous stream across the bank boundary
    @(negedge clk);
    exp_fetch(0);
    exp_fetch(1);
    exp_fetch(2);
    exp_fetch(3);
    exp_fetch(1024);
    exp_fetch(1025);
    exp_fetch(1026);
    en = 1'b1;
    wait_words(6, 4500, "stream_words");
    repeat (230) @(negedge clk);
    check_val("fetch_queue_drained", addr_q.size(), 0);
    check_val("word0_exact", int'(rx_words[0]), 12'h801);
    check_val("word1_exact", int'(rx_words[1]), 12'hFFE);
    check_val("frameStart_count_a", fs_cnt, 2);

    // Asynchronous reset in the middle of a bit of word 1026
    @(negedge clk);
    #3 rst = 1'b0;
    en = 1'b0;
    #1 check_quiet("async_reset_midbit", 1'b1);
    repeat (2) @(negedge clk);
    check_quiet("reset_held", 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    base = words_done;

    // Restart from addr 0, drop en during word 2
    @(negedge clk);
    exp_fetch(0);
    exp_fetch(1);
    exp_fetch(2);
    en = 1'b1;
    wait_words(base + 2, 1500, "restart_words");
    repeat (100) @(negedge clk);
    en = 1'b0;
    wait_idle(1000, "stop_idle");
    check_val("word2_completed", words_done, base + 3);
    check_val("serOut_idle", int'(serOut), 0);
    check_val("sw_out_kept", int'(sw_out), 1);
    repeat (100) @(negedge clk);

    // Resume at the next index, crossing into bank 1
    exp_fetch(3);
    exp_fetch(1024);
    en = 1'b1;
    wait_words(base + 4, 1500, "resume_words");
    repeat (5) @(negedge clk);
    en = 1'b0;
    wait_idle(1000, "final_idle");
    check_val("final_words", words_done, base + 5);
    check_val("final_fetch_queue", addr_q.size(), 0);
    check_val("final_word_queue", word_q.size(), 0);
    check_val("final_sw_out", int'(sw_out), 0);
    check_val("frameStart_count_total", fs_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
